ram_pattern_sequencer: RTL and testbench

Self-checking command source for the single-port RAM wrapper's packed command word. On a start pulse it writes a deterministic pattern to every one of the 64 locations, reads every location back, and compares each returned word against the expected value. It accounts for the wrapper's read latency with an expected-value pipeline and reports pass/fail, an error count and the first failing address. It sits directly in front of the RAM wrapper in the negative-edge test designs and drives the wrapper's `data_in`.

---
 rtl/ram_pattern_sequencer_pkg.sv | 44 ++++
 rtl/ram_pattern_sequencer_expect_pipe.sv | 27 ++
 rtl/ram_pattern_sequencer.sv | 119 +++++++++++
 tb/tb_ram_pattern_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_pattern_sequencer_pkg.sv
// Shared packing and pattern helpers for the RAM wrapper command word.
// Imported by the sequencer and by the RAM wrapper's bench.
package ram_pattern_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } seq_state_e;

  localparam int CMD_W           = 32;
  localparam int CMD_WE_BIT      = 0;
  localparam int CMD_ADDR_LSB    = 1;
  localparam int CMD_ADDR_W      = 6;
  localparam int CMD_PAYLOAD_LSB = 7;
  localparam int CMD_PAYLOAD_W   = CMD_W - CMD_PAYLOAD_LSB;

  typedef struct packed {
    logic                  valid;
    logic [CMD_W-1:0]      word;
    logic [CMD_ADDR_W-1:0] addr;
  } expect_t;

  // The written command doubles as the expected read value.
  function automatic logic [CMD_W-1:0] patternWord(input logic [CMD_PAYLOAD_W-1:0] seed,
                                                   input logic [CMD_ADDR_W-1:0] addr);
    logic [CMD_W-1:0] w;
    w = '0;
    w[CMD_WE_BIT] = 1'b1;
    w[CMD_ADDR_LSB +: CMD_ADDR_W] = addr;
    w[CMD_PAYLOAD_LSB +: CMD_PAYLOAD_W] = seed ^ {19'd0, ~addr};
    return w;
  endfunction

  function automatic logic [CMD_W-1:0] readCmd(input logic [CMD_ADDR_W-1:0] addr);
    logic [CMD_W-1:0] w;
    w = '0;
    w[CMD_ADDR_LSB +: CMD_ADDR_W] = addr;
    return w;
  endfunction

endpackage

// File: rtl/ram_pattern_sequencer_expect_pipe.sv
// Expected-value delay line matching the RAM wrapper's read latency.
// The tail lines up with the read data returned for the pushed entry.
module expect_pipe
  import ram_pattern_sequencer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  expect_t entry_i,
  output expect_t tail_o
);

  expect_t stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= entry_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tail_o = stage_q[DEPTH-1];

endmodule

// File: rtl/ram_pattern_sequencer.sv
// Writes a seeded pattern to all 64 RAM locations, reads them back and
// reports pass/fail, error count and the first failing address.
module ram_pattern_sequencer
  import ram_pattern_sequencer_pkg::*;
#(
  parameter logic [24:0] SEED   = 25'h0A55A5A,
  parameter int          RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] mem_cmd,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [6:0]  err_count,
  output logic [5:0]  first_err_addr
);

  seq_state_e  state_q, state_d;
  logic [5:0]  addr_q, addr_d;
  logic [2:0]  drain_q, drain_d;
  logic [6:0]  err_q, err_d;
  logic [5:0]  ferr_q, ferr_d;
  logic [31:0] cmd_q, cmd_d;
  logic        busy_q, done_q, pass_q;
  logic        mismatch;
  expect_t     entry, tail;

  assign entry.valid = (state_q == READ);
  assign entry.word  = patternWord(SEED, addr_q);
  assign entry.addr  = addr_q;

  expect_pipe #(.DEPTH(RD_LAT)) u_expect_pipe (
    .clk     (clk),
    .rst     (rst),
    .entry_i (entry),
    .tail_o  (tail)
  );

  assign mismatch = tail.valid && (mem_rdata != tail.word);

  // State and addr always describe the command currently on mem_cmd.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    if (mismatch) begin
      if (err_q != 7'd64) err_d = err_q + 7'd1;
      if (err_q == 7'd0)  ferr_d = tail.addr;
    end
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = WRITE;
          addr_d  = 6'd0;
          err_d   = 7'd0;
          ferr_d  = 6'd0;
        end
      end
      WRITE: begin
        addr_d = addr_q + 6'd1;
        if (addr_q == 6'd63) state_d = READ;
      end
      READ: begin
        addr_d = addr_q + 6'd1;
        if (addr_q == 6'd63) begin
          state_d = DRAIN;
          drain_d = 3'd0;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 3'd1;
        if (drain_q == 3'(RD_LAT - 1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    case (state_d)
      WRITE:   cmd_d = patternWord(SEED, addr_d);
      READ:    cmd_d = readCmd(addr_d);
      default: cmd_d = readCmd(6'd0);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      drain_q <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      cmd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      cmd_q   <= cmd_d;
      busy_q  <= (state_d == WRITE) || (state_d == READ) || (state_d == DRAIN);
      done_q  <= (state_d == DONE);
      pass_q  <= (state_d == DONE) && (err_d == 7'd0);
    end
  end

  assign mem_cmd        = cmd_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;

endmodule

// File: tb/tb_ram_pattern_sequencer.sv
// Bench for ram_pattern_sequencer: behavioural RAM with corruption injection,
// a timeline-based reference model checked every cycle, plus directed literals.
module tb_ram_pattern_sequencer;

  localparam int          RD_LAT = 2;
  localparam logic [24:0] SEED   = 25'h0A55A5A;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] mem_cmd;
  logic [31:0] mem_rdata;
  logic        busy, done, pass;
  logic [6:0]  err_count;
  logic [5:0]  first_err_addr;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit checkEn = 0;

  logic [31:0] ram [64];
  logic [31:0] dqData [RD_LAT];
  logic [5:0]  dqAddr [RD_LAT];
  logic [31:0] negData;
  logic [5:0]  negAddr;
  logic [31:0] curMask [64];
  logic [31:0] pendMask [64];
  bit          curZero, pendZero;
  bit          hasRun;
  int          runT;

  ram_pattern_sequencer #(.SEED(SEED), .RD_LAT(RD_LAT)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mem_cmd        (mem_cmd),
    .mem_rdata      (mem_rdata),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [31:0] modelWord(input int a);
    logic [5:0] a6;
    a6 = 6'(a);
    return {SEED ^ {19'd0, ~a6}, a6, 1'b1};
  endfunction

  // Wrapper stand-in: captures the command on negedge, returns read data RD_LAT posedges later.
  always @(negedge clk) begin
    negAddr = mem_cmd[6:1];
    negData = ram[negAddr];
    if (mem_cmd[0]) ram[negAddr] = mem_cmd;
  end

  // Run bookkeeping for the model plus the read-return delay line.
  always @(posedge clk) begin
    if (rst) hasRun = 0;
    else if (start && (!hasRun || (cyc - runT) >= 129 + RD_LAT)) begin
      hasRun  = 1;
      runT    = cyc;
      curMask = pendMask;
      curZero = pendZero;
    end
    for (int i = RD_LAT - 1; i > 0; i--) begin
      dqData[i] = dqData[i-1];
      dqAddr[i] = dqAddr[i-1];
    end
    dqData[0] = negData;
    dqAddr[0] = negAddr;
    mem_rdata <= curZero ? 32'd0 : (dqData[RD_LAT-1] ^ curMask[dqAddr[RD_LAT-1]]);
    cyc++;
  end

  // Expected outputs derived from the position k within the current run.
  always @(negedge clk) begin
    int k, n, f;
    logic [31:0] eCmd;
    bit eBusy, eDone;
    if (checkEn) begin
      eCmd = 0; eBusy = 0; eDone = 0; n = 0; f = 0;
      if (hasRun) begin
        k = cyc - runT;
        if (k >= 1 && k <= 64)        eCmd = modelWord(k - 1);
        else if (k >= 65 && k <= 128) eCmd = 32'(k - 65) << 1;
        eBusy = (k >= 1) && (k <= 128 + RD_LAT);
        eDone = (k >= 129 + RD_LAT);
        for (int a = 0; a < 64; a++) begin
          if (a <= k - 66 - RD_LAT && (curZero || curMask[a] != 0)) begin
            if (n == 0) f = a;
            n++;
          end
        end
        if (n > 64) n = 64;
      end
      checkOutput("mem_cmd", mem_cmd, eCmd);
      checkOutput("busy", 32'(busy), 32'(eBusy));
      checkOutput("done", 32'(done), 32'(eDone));
      checkOutput("pass", 32'(pass), 32'(eDone && n == 0));
      checkOutput("err_count", 32'(err_count), 32'(n));
      checkOutput("first_err_addr", 32'(first_err_addr), 32'(f));
    end
  end

  // Drives rst/start for the current cycle and returns at the next negedge.
  task automatic applyStimulus(input logic r, input logic s);
    rst   = r;
    start = s;
    @(negedge clk);
  endtask

  task automatic clearProfile();
    for (int a = 0; a < 64; a++) pendMask[a] = 32'd0;
    pendZero = 0;
  endtask

  task automatic runAndCheck(input string name, input int midStart, input int rstAt,
                             input bit lit, input int expErr, input int expFirst, input bit expPass);
    int t;
    bit fin;
    t = cyc;
    applyStimulus(0, 1);
    checkOutput({name, "_cmdW0"}, mem_cmd, 32'h52AD3281);
    checkOutput({name, "_doneClr"}, 32'(done), 32'd0);
    checkOutput({name, "_errClr"}, 32'(err_count), 32'd0);
    fin = 0;
    for (int i = 0; i < 400 && !fin; i++) begin
      if (cyc - t == 66) checkOutput({name, "_cmdRd1"}, mem_cmd, 32'h2);
      if (rstAt >= 0 && cyc - t == rstAt) begin
        applyStimulus(1, 0);
        checkOutput({name, "_rstCmd"}, mem_cmd, 32'd0);
        checkOutput({name, "_rstBusy"}, 32'(busy), 32'd0);
        checkOutput({name, "_rstErr"}, 32'(err_count), 32'd0);
        applyStimulus(0, 0);
        return;
      end
      if (done) fin = 1;
      else applyStimulus(0, (cyc - t) == midStart);
    end
    checkOutput({name, "_doneCycle"}, 32'(cyc - t), 32'd131);
    if (lit) begin
      checkOutput({name, "_err"}, 32'(err_count), 32'(expErr));
      checkOutput({name, "_first"}, 32'(first_err_addr), 32'(expFirst));
      checkOutput({name, "_pass"}, 32'(pass), 32'(expPass));
    end
  endtask

  initial begin
    for (int a = 0; a < 64; a++) ram[a] = 32'd0;
    for (int i = 0; i < RD_LAT; i++) begin
      dqData[i] = 32'd0;
      dqAddr[i] = 6'd0;
    end
    negData = 0; negAddr = 0; mem_rdata = 0;
    hasRun = 0; runT = 0; curZero = 0;
    for (int a = 0; a < 64; a++) curMask[a] = 32'd0;
    clearProfile();
    rst = 1; start = 0;
    repeat (3) @(negedge clk);
    checkEn = 1;
    checkOutput("reset_cmd", mem_cmd, 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_first", 32'(first_err_addr), 32'd0);
    applyStimulus(0, 0);
    applyStimulus(1, 1);
    checkOutput("rstWinsBusy", 32'(busy), 32'd0);
    applyStimulus(0, 0);
    checkOutput("rstWinsIdle", 32'(busy), 32'd0);

    runAndCheck("clean", -1, -1, 1, 0, 0, 1);
    pendMask[5] = 32'h1 << 20;
    runAndCheck("bit20", -1, -1, 1, 1, 5, 0);
    clearProfile();
    pendZero = 1;
    runAndCheck("zeros", -1, -1, 1, 64, 0, 0);
    clearProfile();
    runAndCheck("midStart", 10, -1, 1, 0, 0, 1);
    runAndCheck("rstRead", -1, 80, 0, 0, 0, 0);
    runAndCheck("afterRst", -1, -1, 1, 0, 0, 1);
    runAndCheck("b2b", -1, -1, 1, 0, 0, 1);

    for (int r = 0; r < 4; r++) begin
      clearProfile();
      for (int j = 0; j < int'($urandom_range(1, 4)); j++)
        pendMask[$urandom_range(0, 63)] |= 32'h1 << $urandom_range(0, 31);
      runAndCheck("random", -1, -1, 0, 0, 0, 0);
    end
    clearProfile();
    runAndCheck("final", -1, -1, 1, 0, 0, 1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
